// File: rtl/round_key_sequencer_pkg.sv
// Shared AES definitions: round-key types, sequencer state encoding and the
// key-size to round-count mapping used by the encoder, decoder and sequencer.
package round_key_sequencer_pkg;

    localparam int AES_STATE_SIZE = 128;

    typedef logic [7:0]                byte_t;
    typedef logic [AES_STATE_SIZE-1:0] roundKey_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        STREAM = 2'd2
    } seqState_t;

    // Number of cipher rounds for a given key width; unknown widths fall back to AES-128.
    function automatic int numRounds(input int keySize);
        case (keySize)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

endpackage

// File: rtl/round_key_sequencer_if.sv
// Load / start / key-stream handshake bundle between ExpandKey, the cipher
// control and the round datapath on one side and the key sequencer on the other.
interface round_key_sequencer_if
    import round_key_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) ();

    logic                        loadValid;
    logic                        loadReady;
    roundKey_t [0:NUM_ROUNDS]    roundKeys;
    logic                        startValid;
    logic                        startReady;
    logic                        decrypt;
    logic                        keyValid;
    logic                        keyReady;
    roundKey_t                   roundKey;
    logic [IDX_W-1:0]            roundIdx;
    logic                        lastKey;

    // Producer/consumer side of the sequencer.
    modport master (
        output loadValid, roundKeys, startValid, decrypt, keyReady,
        input  loadReady, startReady, keyValid, roundKey, roundIdx, lastKey
    );

    // The sequencer itself.
    modport slave (
        input  loadValid, roundKeys, startValid, decrypt, keyReady,
        output loadReady, startReady, keyValid, roundKey, roundIdx, lastKey
    );

endinterface

// File: rtl/round_key_sequencer.sv
// Round-key sequencer: captures the whole ExpandKey schedule on a load
// handshake and replays it one key per accepted handshake, forward for
// encryption and backward for decryption, until a new schedule is loaded.
module round_key_sequencer
    import round_key_sequencer_pkg::*;
#(
    parameter int KEY_SIZE   = 128,
    parameter int NUM_ROUNDS = numRounds(KEY_SIZE),
    parameter int IDX_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    round_key_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] IDX_FIRST = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] IDX_STEP  = IDX_W'(1);

    seqState_t        state_r,     state_s;
    logic             decrypt_r,   decrypt_s;
    logic             key_valid_r, key_valid_s;
    roundKey_t        round_key_r, round_key_s;
    logic [IDX_W-1:0] round_idx_r, round_idx_s;
    logic             last_key_r,  last_key_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             key_update_s;
    logic             load_fire_s;
    logic             start_fire_s;
    logic             accept_s;

    roundKey_t        store_r [0:NUM_ROUNDS];

    assign bus.loadReady  = (state_r != STREAM);
    assign bus.startReady = (state_r == LOADED);
    assign bus.keyValid   = key_valid_r;
    assign bus.roundKey   = round_key_r;
    assign bus.roundIdx   = round_idx_r;
    assign bus.lastKey    = last_key_r;

    assign load_fire_s  = bus.loadValid  && (state_r != STREAM);
    assign start_fire_s = bus.startValid && (state_r == LOADED);
    assign accept_s     = key_valid_r    && bus.keyReady;

    // Next-state and next-output decode; a key slot is (re)read only on start or advance.
    always_comb begin
        state_s      = state_r;
        decrypt_s    = decrypt_r;
        key_valid_s  = key_valid_r;
        round_idx_s  = round_idx_r;
        last_key_s   = last_key_r;
        rd_idx_s     = round_idx_r;
        key_update_s = 1'b0;
        round_key_s  = round_key_r;

        case (state_r)
            EMPTY: begin
                if (load_fire_s) begin
                    state_s = LOADED;
                end else begin
                    state_s = EMPTY;
                end
            end
            LOADED: begin
                if (start_fire_s) begin
                    state_s      = STREAM;
                    decrypt_s    = bus.decrypt;
                    rd_idx_s     = bus.decrypt ? IDX_LAST : IDX_FIRST;
                    key_update_s = 1'b1;
                end else begin
                    state_s = LOADED;
                end
            end
            STREAM: begin
                if (accept_s && last_key_r) begin
                    // Final key taken: go idle, never wrap the index.
                    state_s     = LOADED;
                    key_valid_s = 1'b0;
                end else if (accept_s) begin
                    rd_idx_s     = decrypt_r ? (round_idx_r - IDX_STEP) : (round_idx_r + IDX_STEP);
                    key_update_s = 1'b1;
                end else begin
                    state_s = STREAM;
                end
            end
            default: begin
                state_s     = EMPTY;
                key_valid_s = 1'b0;
            end
        endcase

        if (key_update_s) begin
            key_valid_s = 1'b1;
            round_idx_s = rd_idx_s;
            last_key_s  = decrypt_s ? (rd_idx_s == IDX_FIRST) : (rd_idx_s == IDX_LAST);
        end else begin
            round_idx_s = round_idx_r;
        end

        // A load in the same cycle as start must stream the incoming schedule.
        if (key_update_s && load_fire_s) begin
            round_key_s = bus.roundKeys[rd_idx_s];
        end else if (key_update_s) begin
            round_key_s = store_r[rd_idx_s];
        end else begin
            round_key_s = round_key_r;
        end
    end

    // Control state and registered stream outputs, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= EMPTY;
            decrypt_r   <= 1'b0;
            key_valid_r <= 1'b0;
            round_key_r <= {AES_STATE_SIZE{1'b0}};
            round_idx_r <= {IDX_W{1'b0}};
            last_key_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            decrypt_r   <= decrypt_s;
            key_valid_r <= key_valid_s;
            round_key_r <= round_key_s;
            round_idx_r <= round_idx_s;
            last_key_r  <= last_key_s;
        end
    end

    // Schedule storage; contents are meaningless while state is EMPTY, so no reset.
    always_ff @(posedge clock) begin
        if (load_fire_s) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                store_r[i] <= bus.roundKeys[i];
            end
        end
    end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer: an AES-128 instance carrying the
// FIPS-197 schedule and an AES-256 instance (14 rounds) for the load+start case.
module tb_round_key_sequencer;
    import round_key_sequencer_pkg::*;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    round_key_sequencer_if #(.NUM_ROUNDS(10), .IDX_W(4)) bus_a ();
    round_key_sequencer_if #(.NUM_ROUNDS(14), .IDX_W(4)) bus_b ();

    round_key_sequencer #(.KEY_SIZE(128), .NUM_ROUNDS(10), .IDX_W(4)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    round_key_sequencer #(.KEY_SIZE(256), .NUM_ROUNDS(14), .IDX_W(4)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // FIPS-197 Appendix C.1 key schedule for key 000102030405060708090a0b0c0d0e0f.
    roundKey_t sched_a [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adac71a2,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Synthetic round key: every byte is sel*32 + index, so schedules are distinct.
    function automatic roundKey_t patkey(input int sel, input int i);
        byte_t b;
        b = 8'(sel * 32 + i);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_k(input string tag, input roundKey_t obs, input roundKey_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input int sel);
        for (int i = 0; i <= 10; i++) begin
            bus_a.roundKeys[i] = (sel == 0) ? sched_a[i] : patkey(sel, i);
        end
        bus_a.loadValid = 1'b1;
        tick();
        bus_a.loadValid = 1'b0;
        // Scramble the input so later checks prove keys come from storage.
        for (int i = 0; i <= 10; i++) begin
            bus_a.roundKeys[i] = patkey(7, i);
        end
    endtask

    // One full stream on instance A checked against sched_a; optional random
    // backpressure and an optional blocked load attempt during the stream.
    task automatic stream_a(input bit dec, input bit bp, input bit blk, input string tag);
        int  k;
        int  budget;
        int  exp_idx;
        bit  rdy;
        bus_a.decrypt    = dec;
        bus_a.keyReady   = 1'b1;
        bus_a.startValid = 1'b1;
        tick();
        bus_a.startValid = 1'b0;
        k      = 0;
        budget = 0;
        while (k < 11 && budget < 200) begin
            exp_idx = dec ? (10 - k) : k;
            chk_b($sformatf("%s valid k%0d", tag, k), bus_a.keyValid, 1'b1);
            chk_k($sformatf("%s key k%0d", tag, k), bus_a.roundKey, sched_a[exp_idx]);
            chk_i($sformatf("%s idx k%0d", tag, k), bus_a.roundIdx, 4'(exp_idx));
            chk_b($sformatf("%s last k%0d", tag, k), bus_a.lastKey, (k == 10));
            if (blk && k >= 3) begin
                chk_b($sformatf("%s loadReady k%0d", tag, k), bus_a.loadReady, 1'b0);
            end
            if (blk && k == 3) begin
                for (int i = 0; i <= 10; i++) begin
                    bus_a.roundKeys[i] = patkey(5, i);
                end
                bus_a.loadValid = 1'b1;
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_a.keyReady = rdy;
            tick();
            if (rdy) begin
                k++;
            end
            budget++;
        end
        bus_a.keyReady = 1'b1;
        chk_i($sformatf("%s handshakes", tag), 4'(k), 4'd11);
        chk_b($sformatf("%s end valid", tag), bus_a.keyValid, 1'b0);
        chk_b($sformatf("%s end startReady", tag), bus_a.startReady, 1'b1);
        if (blk) begin
            chk_b($sformatf("%s held load ready", tag), bus_a.loadReady, 1'b1);
            tick();
            bus_a.loadValid = 1'b0;
        end
    endtask

    // Directed test sequence.
    initial begin
        int k;
        int budget;
        clock = 1'b0;
        reset = 1'b1;
        n_vec = 0;
        n_err = 0;
        bus_a.loadValid  = 1'b0;
        bus_a.startValid = 1'b0;
        bus_a.decrypt    = 1'b0;
        bus_a.keyReady   = 1'b1;
        bus_b.loadValid  = 1'b0;
        bus_b.startValid = 1'b0;
        bus_b.decrypt    = 1'b0;
        bus_b.keyReady   = 1'b1;
        for (int i = 0; i <= 10; i++) bus_a.roundKeys[i] = patkey(7, i);
        for (int i = 0; i <= 14; i++) bus_b.roundKeys[i] = patkey(7, i);
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk_b("rst keyValid", bus_a.keyValid, 1'b0);
        chk_k("rst roundKey", bus_a.roundKey, 128'h0);
        chk_i("rst roundIdx", bus_a.roundIdx, 4'd0);
        chk_b("rst lastKey", bus_a.lastKey, 1'b0);
        chk_b("rst loadReady", bus_a.loadReady, 1'b1);
        chk_b("rst startReady", bus_a.startReady, 1'b0);

        // Start while EMPTY is ignored.
        bus_a.startValid = 1'b1;
        tick();
        tick();
        bus_a.startValid = 1'b0;
        chk_b("empty start keyValid", bus_a.keyValid, 1'b0);
        chk_b("empty start startReady", bus_a.startReady, 1'b0);

        // Load, then encrypt, decrypt, backpressured and replayed streams.
        load_a(0);
        chk_b("loaded startReady", bus_a.startReady, 1'b1);
        chk_b("loaded loadReady", bus_a.loadReady, 1'b1);
        stream_a(1'b0, 1'b0, 1'b0, "enc");
        stream_a(1'b1, 1'b0, 1'b0, "dec");
        stream_a(1'b0, 1'b1, 1'b0, "bp");
        stream_a(1'b0, 1'b0, 1'b0, "replay");

        // Load held during a stream must not disturb it.
        stream_a(1'b0, 1'b0, 1'b1, "blk");
        load_a(0);
        stream_a(1'b0, 1'b0, 1'b0, "reload");

        // 14-round instance: load schedule 1, then load schedule 2 together with start.
        for (int i = 0; i <= 14; i++) bus_b.roundKeys[i] = patkey(1, i);
        bus_b.loadValid = 1'b1;
        tick();
        bus_b.loadValid = 1'b0;
        chk_b("b loaded startReady", bus_b.startReady, 1'b1);
        for (int i = 0; i <= 14; i++) bus_b.roundKeys[i] = patkey(2, i);
        bus_b.loadValid  = 1'b1;
        bus_b.startValid = 1'b1;
        tick();
        bus_b.loadValid  = 1'b0;
        bus_b.startValid = 1'b0;
        for (int i = 0; i <= 14; i++) bus_b.roundKeys[i] = patkey(7, i);
        k      = 0;
        budget = 0;
        while (k < 15 && budget < 100) begin
            chk_b($sformatf("b valid k%0d", k), bus_b.keyValid, 1'b1);
            chk_k($sformatf("b key k%0d", k), bus_b.roundKey, patkey(2, k));
            chk_i($sformatf("b idx k%0d", k), bus_b.roundIdx, 4'(k));
            chk_b($sformatf("b last k%0d", k), bus_b.lastKey, (k == 14));
            tick();
            k++;
            budget++;
        end
        chk_b("b end valid", bus_b.keyValid, 1'b0);

        // Reset in the middle of a stream, at index 5.
        bus_a.decrypt    = 1'b0;
        bus_a.keyReady   = 1'b1;
        bus_a.startValid = 1'b1;
        tick();
        bus_a.startValid = 1'b0;
        repeat (5) tick();
        chk_i("pre-reset idx", bus_a.roundIdx, 4'd5);
        chk_k("pre-reset key", bus_a.roundKey, sched_a[5]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_b("midrst keyValid", bus_a.keyValid, 1'b0);
        chk_b("midrst startReady", bus_a.startReady, 1'b0);
        chk_b("midrst loadReady", bus_a.loadReady, 1'b1);
        chk_i("midrst roundIdx", bus_a.roundIdx, 4'd0);
        bus_a.startValid = 1'b1;
        tick();
        tick();
        bus_a.startValid = 1'b0;
        chk_b("post-reset start keyValid", bus_a.keyValid, 1'b0);
        chk_b("post-reset startReady", bus_a.startReady, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
